// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the write-back stage:
// data-source encodings, FSM states and the MEM/WB bundle.
package writeback_stage_pkg;

    localparam logic [2:0] WB_SRC_ALU  = 3'd0;
    localparam logic [2:0] WB_SRC_MEM  = 3'd1;
    localparam logic [2:0] WB_SRC_PC   = 3'd2;
    localparam logic [2:0] WB_SRC_IMM  = 3'd3;
    localparam logic [2:0] WB_SRC_FLAG = 3'd4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_e;

    // Only the low instruction byte is ever consumed (immediate source).
    typedef struct packed {
        logic        valid;
        logic        reg_wrt;
        logic [2:0]  write_reg;
        logic [2:0]  src;
        logic        mem_to_reg;
        logic [15:0] alu_res;
        logic [15:0] mem_data;
        logic [15:0] next_pc;
        logic [7:0]  imm8;
        logic        flag;
        logic        halt;
        logic        err;
    } mem_wb_t;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/writeback_stage_dff.sv
// Enabled register with synchronous active-low clear.
// Building block for every piece of write-back state.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear on reset, otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/writeback_stage_wb_data_mux.sv
// Write-back data source select.
// Flags any source encoding outside the defined set.
module wb_data_mux
    import writeback_stage_pkg::*;
(
    input  logic        mem_to_reg,
    input  logic [2:0]  src,
    input  logic [15:0] alu_res,
    input  logic [15:0] mem_data,
    input  logic [15:0] next_pc,
    input  logic [7:0]  imm8,
    input  logic        flag,
    output logic [15:0] data,
    output logic        bad
);

    // Memory load overrides the source field; unknown sources give zero.
    always_comb begin
        data = '0;
        bad  = 1'b0;
        if (mem_to_reg) begin
            data = mem_data;
        end else begin
            case (src)
                WB_SRC_ALU:  data = alu_res;
                WB_SRC_MEM:  data = mem_data;
                WB_SRC_PC:   data = next_pc;
                WB_SRC_IMM:  data = sext8(imm8);
                WB_SRC_FLAG: data = {15'b0, flag};
                default:     bad  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB latch, register write port,
// sticky halt/error state and retired-instruction counter.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             validIn,
    input  logic             regWrtIn,
    input  logic [2:0]       writeRegIn,
    input  logic [2:0]       regWrtSrcIn,
    input  logic             memToRegIn,
    input  logic [15:0]      aluResIn,
    input  logic [15:0]      memDataIn,
    input  logic [15:0]      nextPcIn,
    input  logic [15:0]      instrIn,
    input  logic             flagIn,
    input  logic             haltIn,
    input  logic             errIn,
    output logic             regWrtEn,
    output logic [2:0]       regWrtAddr,
    output logic [15:0]      regWrtData,
    output logic             halt,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam int LAT_W = $bits(mem_wb_t);

    mem_wb_t          lat_d;
    mem_wb_t          lat_q;
    logic [LAT_W-1:0] lat_qv;
    logic             state_q;
    wb_state_e        state;
    logic             run;
    logic             bad;
    logic             retire;
    logic             stop;
    logic             halt_set;
    logic             err_set;
    logic [CNT_W-1:0] retired_nx;

    assign lat_d = '{
        valid:      validIn,
        reg_wrt:    regWrtIn,
        write_reg:  writeRegIn,
        src:        regWrtSrcIn,
        mem_to_reg: memToRegIn,
        alu_res:    aluResIn,
        mem_data:   memDataIn,
        next_pc:    nextPcIn,
        imm8:       instrIn[7:0],
        flag:       flagIn,
        halt:       haltIn,
        err:        errIn
    };

    dff #(.W(LAT_W)) u_lat (
        .clk (clk),
        .rst (rst),
        .en  (~stall),
        .d   (lat_d),
        .q   (lat_qv)
    );

    assign lat_q = mem_wb_t'(lat_qv);

    wb_data_mux u_mux (
        .mem_to_reg (lat_q.mem_to_reg),
        .src        (lat_q.src),
        .alu_res    (lat_q.alu_res),
        .mem_data   (lat_q.mem_data),
        .next_pc    (lat_q.next_pc),
        .imm8       (lat_q.imm8),
        .flag       (lat_q.flag),
        .data       (regWrtData),
        .bad        (bad)
    );

    assign state  = wb_state_e'(state_q);
    assign run    = (state == RUN);
    assign retire = lat_q.valid & ~stall & run;

    assign halt_set = retire & lat_q.halt;
    assign err_set  = retire & (lat_q.err | bad);
    assign stop     = halt_set | err_set;

    // HALTED is absorbing: only reset clears it.
    dff #(.W(1)) u_state (
        .clk (clk),
        .rst (rst),
        .en  (stop),
        .d   (1'(HALTED)),
        .q   (state_q)
    );

    dff #(.W(1)) u_halt (
        .clk (clk),
        .rst (rst),
        .en  (halt_set),
        .d   (1'b1),
        .q   (halt)
    );

    dff #(.W(1)) u_err (
        .clk (clk),
        .rst (rst),
        .en  (err_set),
        .d   (1'b1),
        .q   (err)
    );

    assign retired_nx = retired + CNT_W'(1);

    dff #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (retire),
        .d   (retired_nx),
        .q   (retired)
    );

    // HALT never writes; nothing writes while reset is asserted.
    assign regWrtEn = lat_q.valid & lat_q.reg_wrt & ~lat_q.halt
                    & run & rst;
    assign regWrtAddr = lat_q.write_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        validIn;
    logic        regWrtIn;
    logic [2:0]  writeRegIn;
    logic [2:0]  regWrtSrcIn;
    logic        memToRegIn;
    logic [15:0] aluResIn;
    logic [15:0] memDataIn;
    logic [15:0] nextPcIn;
    logic [15:0] instrIn;
    logic        flagIn;
    logic        haltIn;
    logic        errIn;
    logic        regWrtEn;
    logic [2:0]  regWrtAddr;
    logic [15:0] regWrtData;
    logic        halt;
    logic        err;
    logic [15:0] retired;

    int checks   = 0;
    int failures = 0;

    // Model: the instruction currently waiting to write back,
    // plus the architectural stop/halt/error/count state.
    logic        m_valid;
    logic        m_rw;
    logic [2:0]  m_wreg;
    logic [2:0]  m_src;
    logic        m_m2r;
    logic [15:0] m_alu;
    logic [15:0] m_mem;
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic        m_flag;
    logic        m_hi;
    logic        m_ei;
    logic        m_stopped;
    logic        m_halt;
    logic        m_err;
    int          m_cnt;

    writeback_stage #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .validIn     (validIn),
        .regWrtIn    (regWrtIn),
        .writeRegIn  (writeRegIn),
        .regWrtSrcIn (regWrtSrcIn),
        .memToRegIn  (memToRegIn),
        .aluResIn    (aluResIn),
        .memDataIn   (memDataIn),
        .nextPcIn    (nextPcIn),
        .instrIn     (instrIn),
        .flagIn      (flagIn),
        .haltIn      (haltIn),
        .errIn       (errIn),
        .regWrtEn    (regWrtEn),
        .regWrtAddr  (regWrtAddr),
        .regWrtData  (regWrtData),
        .halt        (halt),
        .err         (err),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_data();
        if (m_m2r) return m_mem;
        if (m_src == 3'd0) return m_alu;
        if (m_src == 3'd1) return m_mem;
        if (m_src == 3'd2) return m_pc;
        if (m_src == 3'd3) begin
            if (m_instr[7]) return 16'hFF00 | {8'h00, m_instr[7:0]};
            return {8'h00, m_instr[7:0]};
        end
        if (m_src == 3'd4) return m_flag ? 16'd1 : 16'd0;
        return 16'h0000;
    endfunction

    function automatic logic exp_en();
        return rst && m_valid && m_rw && !m_hi && !m_stopped;
    endfunction

    task automatic model_edge();
        logic bad;
        if (!rst) begin
            m_valid = 0; m_rw = 0; m_wreg = 0; m_src = 0;
            m_m2r = 0; m_alu = 0; m_mem = 0; m_pc = 0;
            m_instr = 0; m_flag = 0; m_hi = 0; m_ei = 0;
            m_stopped = 0; m_halt = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (m_valid && !stall && !m_stopped) begin
                m_cnt = (m_cnt + 1) % 65536;
                bad = !m_m2r && (m_src > 3'd4);
                if (m_hi) m_halt = 1;
                if (m_ei || bad) m_err = 1;
                if (m_hi || m_ei || bad) m_stopped = 1;
            end
            if (!stall) begin
                m_valid = validIn;  m_rw = regWrtIn;
                m_wreg = writeRegIn; m_src = regWrtSrcIn;
                m_m2r = memToRegIn; m_alu = aluResIn;
                m_mem = memDataIn;  m_pc = nextPcIn;
                m_instr = instrIn;  m_flag = flagIn;
                m_hi = haltIn;      m_ei = errIn;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic rw,
                         input logic [2:0] wr, input logic [2:0] src,
                         input logic m2r, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [15:0] ins,
                         input logic flg, input logic h, input logic e);
        validIn = v; regWrtIn = rw; writeRegIn = wr;
        regWrtSrcIn = src; memToRegIn = m2r; aluResIn = alu;
        memDataIn = mem; nextPcIn = 16'h0100; instrIn = ins;
        flagIn = flg; haltIn = h; errIn = e;
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 0;
        stall = 0;
        tick();
        rst = 1;
        bubble();
    endtask

    task automatic test_reset();
        rst = 0;
        stall = 0;
        drive(1, 1, 3'd7, 3'd0, 0, 16'hAAAA, 0, 0, 0, 0, 0);
        tick();
        tick();
        checks++;
        if (regWrtEn !== 1'b0 || regWrtAddr !== 3'd0 ||
            regWrtData !== 16'h0) begin
            failures++;
            $display("FAIL reset_port: en=%b addr=%0d data=%h want 0/0/0",
                     regWrtEn, regWrtAddr, regWrtData);
        end
        checks++;
        if (halt !== 1'b0 || err !== 1'b0 || retired !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: halt=%b err=%b ret=%h want 0/0/0",
                     halt, err, retired);
        end
        rst = 1;
        bubble();
    endtask

    task automatic test_alu_writes();
        logic [15:0] vals [3];
        vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 3'(i + 1), 3'd0, 0, vals[i], 16'h7777, 0, 0, 0, 0);
            tick();
            checks++;
            if (regWrtEn !== 1'b1 || regWrtAddr !== 3'(i + 1) ||
                regWrtData !== vals[i] || retired !== 16'(i)) begin
                failures++;
                $display("FAIL alu_write%0d: en=%b a=%0d d=%h r=%0d want 1/%0d/%h/%0d",
                         i, regWrtEn, regWrtAddr, regWrtData, retired,
                         i + 1, vals[i], i);
            end
        end
        bubble();
        tick();
        checks++;
        if (regWrtEn !== 1'b0 || retired !== 16'd3) begin
            failures++;
            $display("FAIL alu_retired: en=%b ret=%0d want 0/3",
                     regWrtEn, retired);
        end
    endtask

    task automatic test_select();
        do_reset();
        drive(1, 1, 3'd4, 3'd0, 1, 16'h1234, 16'hBEEF, 0, 0, 0, 0);
        tick();
        checks++;
        if (regWrtData !== 16'hBEEF) begin
            failures++;
            $display("FAIL sel_memtoreg: got %h want beef", regWrtData);
        end
        drive(1, 1, 3'd4, 3'd3, 0, 16'h1234, 16'hBEEF, 16'h1280, 0, 0, 0);
        tick();
        checks++;
        if (regWrtData !== 16'hFF80) begin
            failures++;
            $display("FAIL sel_imm: got %h want ff80", regWrtData);
        end
        drive(1, 1, 3'd4, 3'd4, 0, 16'h1234, 16'hBEEF, 16'h1280, 1, 0, 0);
        tick();
        checks++;
        if (regWrtData !== 16'h0001) begin
            failures++;
            $display("FAIL sel_flag: got %h want 0001", regWrtData);
        end
        drive(1, 1, 3'd4, 3'd2, 0, 16'h1234, 16'hBEEF, 16'h1280, 1, 0, 0);
        tick();
        checks++;
        if (regWrtData !== 16'h0100) begin
            failures++;
            $display("FAIL sel_pc: got %h want 0100", regWrtData);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 1, 3'd5, 3'd0, 0, 16'h5555, 0, 0, 0, 0, 0);
        tick();
        stall = 1;
        drive(1, 1, 3'd6, 3'd0, 0, 16'h6666, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (regWrtAddr !== 3'd5 || regWrtData !== 16'h5555 ||
                retired !== 16'd0) begin
                failures++;
                $display("FAIL stall_hold%0d: a=%0d d=%h r=%0d want 5/5555/0",
                         i, regWrtAddr, regWrtData, retired);
            end
        end
        stall = 0;
        bubble();
        tick();
        tick();
        checks++;
        if (retired !== 16'd1 || regWrtEn !== 1'b0) begin
            failures++;
            $display("FAIL stall_once: ret=%0d en=%b want 1/0",
                     retired, regWrtEn);
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive(1, 1, 3'd4, 3'd0, 0, 16'h4444, 0, 0, 0, 1, 0);
        tick();
        checks++;
        if (regWrtEn !== 1'b0 || halt !== 1'b0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL halt_latched: en=%b halt=%b ret=%0d want 0/0/0",
                     regWrtEn, halt, retired);
        end
        drive(1, 1, 3'd2, 3'd0, 0, 16'h2222, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (regWrtEn !== 1'b0 || halt !== 1'b1 || err !== 1'b0 ||
            retired !== 16'd1) begin
            failures++;
            $display("FAIL halt_retired: en=%b halt=%b err=%b ret=%0d want 0/1/0/1",
                     regWrtEn, halt, err, retired);
        end
        drive(1, 1, 3'd3, 3'd0, 0, 16'h3333, 0, 0, 0, 0, 0);
        tick();
        tick();
        checks++;
        if (regWrtEn !== 1'b0 || halt !== 1'b1 || retired !== 16'd1) begin
            failures++;
            $display("FAIL halt_frozen: en=%b halt=%b ret=%0d want 0/1/1",
                     regWrtEn, halt, retired);
        end
    endtask

    task automatic test_bad_select();
        do_reset();
        drive(1, 1, 3'd3, 3'd6, 0, 16'h3333, 16'h4444, 16'h00FF, 1, 0, 0);
        tick();
        checks++;
        if (regWrtData !== 16'h0000 || err !== 1'b0) begin
            failures++;
            $display("FAIL bad_data: d=%h err=%b want 0000/0",
                     regWrtData, err);
        end
        drive(1, 1, 3'd1, 3'd0, 0, 16'h1111, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (err !== 1'b1 || halt !== 1'b0 || regWrtEn !== 1'b0 ||
            retired !== 16'd1) begin
            failures++;
            $display("FAIL bad_err: err=%b halt=%b en=%b ret=%0d want 1/0/0/1",
                     err, halt, regWrtEn, retired);
        end
        rst = 0;
        tick();
        checks++;
        if (err !== 1'b0 || halt !== 1'b0 || retired !== 16'd0 ||
            regWrtEn !== 1'b0) begin
            failures++;
            $display("FAIL bad_reset: err=%b halt=%b ret=%0d en=%b want 0/0/0/0",
                     err, halt, retired, regWrtEn);
        end
        rst = 1;
        drive(1, 1, 3'd1, 3'd0, 0, 16'h00AA, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (regWrtEn !== 1'b1 || regWrtAddr !== 3'd1 ||
            regWrtData !== 16'h00AA) begin
            failures++;
            $display("FAIL bad_resume: en=%b a=%0d d=%h want 1/1/00aa",
                     regWrtEn, regWrtAddr, regWrtData);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = !(m_stopped ? ($urandom_range(0, 3) == 0)
                              : ($urandom_range(0, 99) == 0));
            stall = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 29) == 0) ? 3'($urandom_range(5, 7))
                                               : 3'($urandom_range(0, 4)),
                  $urandom_range(0, 5) == 0, 16'($urandom),
                  16'($urandom), 16'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
            nextPcIn = 16'($urandom);
            tick();
            checks++;
            if (regWrtEn !== exp_en() || regWrtAddr !== m_wreg ||
                regWrtData !== exp_data()) begin
                failures++;
                $display("FAIL rand_port@%0d: en=%b a=%0d d=%h want %b/%0d/%h",
                         i, regWrtEn, regWrtAddr, regWrtData,
                         exp_en(), m_wreg, exp_data());
            end
            checks++;
            if (halt !== m_halt || err !== m_err ||
                retired !== 16'(m_cnt)) begin
                failures++;
                $display("FAIL rand_state@%0d: h=%b e=%b r=%0d want %b/%b/%0d",
                         i, halt, err, retired, m_halt, m_err, m_cnt);
            end
        end
        rst = 1;
        stall = 0;
        bubble();
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 0, 3'd1, 3'd0, 0, 16'h0001, 0, 0, 0, 0, 0);
        repeat (65536) tick();
        checks++;
        if (retired !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload: got %h want ffff", retired);
        end
        tick();
        checks++;
        if (retired !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_roll: got %h want 0000", retired);
        end
    endtask

    initial begin
        rst = 0;
        stall = 0;
        bubble();
        nextPcIn = 0;
        test_reset();
        test_alu_writes();
        test_select();
        test_stall();
        test_halt();
        test_bad_select();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Drives the register-file write port of the decode stage: regWrtEn, regWrtAddr and regWrtData.
- Latches the memory-stage results into an MEM/WB register and selects the write-back data.
- Retires instructions, keeps halt and error state sticky, and counts retired instructions for the bench.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset: rst==0 at a rising edge resets all state
- stall  in  1  1 = hold MEM/WB latch contents; capture nothing
- validIn  in  1  memory-stage slot holds a real instruction (0 = bubble)
- regWrtIn  in  1  instruction writes a register
- writeRegIn  in  3  destination register number
- regWrtSrcIn  in  3  write-data source select
- memToRegIn  in  1  1 = memory read data overrides regWrtSrcIn
- aluResIn  in  16  ALU result
- memDataIn  in  16  data-memory read data
- nextPcIn  in  16  PC+2 of this instruction (link value)
- instrIn  in  16  instruction word
- flagIn  in  1  set-condition result
- haltIn  in  1  instruction is HALT
- errIn  in  1  error flagged upstream
- regWrtEn  out  1  register-file write enable
- regWrtAddr  out  3  register-file write address
- regWrtData  out  16  register-file write data
- halt  out  1  sticky: HALT has retired
- err  out  1  sticky: error has retired
- retired  out  CNT_W  count of retired instructions

Behaviour:
- MEM/WB latch loading:
  - stall=0: latch captures all *In signals at each rising edge.
  - stall=1: latch holds its contents; retire events are suppressed while stall=1.
- Outputs come combinationally from the latch, so writeback is one cycle after capture. Decode's bypassing register file handles same-cycle read-after-write.
- Write-data select, in priority order:
  - memToReg=1: memDataIn
  - regWrtSrc 0: aluRes
  - regWrtSrc 1: memData
  - regWrtSrc 2: nextPc
  - regWrtSrc 3: sign-extended instr[7:0]
  - regWrtSrc 4: {15'b0, flag}
  - regWrtSrc 5-7: data = 16'h0 and an internal error is raised
- regWrtEn = latched valid & latched regWrt & state==RUN & ~rst-cycle. regWrtAddr = latched writeReg.
- Retire event: latched valid=1, stall=0, state==RUN.
  - Increments retired by 1; wraps modulo 2^CNT_W.
  - Each latched instruction retires exactly once.
- State machine, 2 states:
  - RUN -> HALTED on a retire event with latched halt=1 or error (errIn or bad select).
  - HALTED is absorbing until reset.
- In HALTED:
  - regWrtEn=0; retired is frozen; halt and err hold their values.
  - New inputs are still latched but have no effect.
- HALT retiring:
  - The HALT instruction itself counts as retired. HALT never writes a register, even if regWrt=1.
  - The halt output rises the cycle after the HALT retires.
- err sets on retirement of an erroneous instruction; it goes to HALTED the same way, and halt stays 0.
- Simultaneous halt and error: both sticky bits set.
- Reset (rst==0 at edge):
  - Latch valid=0 and all latched fields 0; state=RUN; halt=0, err=0, retired=0.
  - Outputs: regWrtEn=0, regWrtAddr=0, regWrtData=0.
  - Reset mid-operation discards the in-flight instruction with no write and no count.

Decomposition:
- Shared definitions file holds:
  - regWrtSrc encodings: WB_SRC_ALU=0, WB_SRC_MEM=1, WB_SRC_PC=2, WB_SRC_IMM=3, WB_SRC_FLAG=4.
  - State encodings: RUN=0, HALTED=1.
- One sub-module: wb_data_mux, the combinational source select plus bad-select error flag.
- Latch, state machine and counter stay in writeback_stage, built from dff instances.

Test Plan:
- Reset then 3 valid ALU writes (r1=16'h0011, r2=16'h0022, r3=16'h0033, src 0) -> each write appears one cycle after capture with regWrtEn=1; retired=3.
- memToReg=1 with regWrtSrc=0, memDataIn=16'hBEEF, aluResIn=16'h1234 -> regWrtData=16'hBEEF. Then src 3, instr[7:0]=8'h80 -> 16'hFF80. Then src 4, flagIn=1 -> 16'h0001.
- Valid write to r5 then stall=1 for 4 cycles -> latch holds; retired increments only once; writeback data is unchanged.
- HALT with regWrt=1, followed by a valid write to r2 -> no write for HALT or r2; halt=1 from the next cycle; retired counts HALT and then freezes.
- regWrtSrc=6 on a valid instruction -> err=1, regWrtEn=0, state HALTED. Then rst=0 for one edge -> err=0, halt=0, retired=0, and writes resume.
- Preload retired=16'hFFFF via 65535 retires (or force), then one more retire -> retired=16'h0000.
